// File: rtl/cic3_sample_buffer_if.sv
// Read-side valid/ready channel of the CIC3 sample buffer.
// The buffer drives the master side; the consumer takes the slave side.
interface cic3_sample_buffer_if #(
  parameter int OUT_WIDTH = 16
);
  logic [OUT_WIDTH-1:0] rd_data;
  logic                 rd_valid;
  logic                 rd_ready;

  modport master (
    output rd_data,
    output rd_valid,
    input  rd_ready
  );

  modport slave (
    input  rd_data,
    input  rd_valid,
    output rd_ready
  );
endinterface

// File: rtl/cic3_sample_buffer.sv
// CIC3 output centering/scaling stage feeding a small sample FIFO.
// Define CIC3_SAMPLE_BUFFER_ROUND_EN for round-half-up instead of floor.
module cic3_sample_buffer #(
  parameter int NUMBITS   = 25,
  parameter int OUT_WIDTH = 16,
  parameter int DEPTH     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUMBITS-1:0]     cic_in,
  input  logic                   sample_stb,
  input  logic                   flush,
  cic3_sample_buffer_if.master   rd,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic                   overflow
);

  localparam int SHIFT = NUMBITS - 1 - OUT_WIDTH;
  localparam int CW    = NUMBITS + 2;
  localparam int AW    = $clog2(DEPTH);

  localparam logic signed [CW-1:0] MID =
    CW'(longint'(1) << (NUMBITS - 2));
  localparam logic signed [CW-1:0] SAT_HI =
    CW'((longint'(1) << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [CW-1:0] SAT_LO = ~SAT_HI;
`ifdef CIC3_SAMPLE_BUFFER_ROUND_EN
  localparam logic signed [CW-1:0] RND =
    CW'(longint'(1) << (SHIFT - 1));
`endif

  logic signed [CW-1:0]  centered;
  logic signed [CW-1:0]  shifted;
  logic [OUT_WIDTH-1:0]  s1_next;
  logic [OUT_WIDTH-1:0]  s1_data;
  logic                  s1_valid;

  logic [OUT_WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic                  full;
  logic                  do_wr;
  logic                  do_rd;

  // Two guard bits keep the centered and rounded value from wrapping.
  always_comb begin
    centered = $signed({2'b00, cic_in}) - MID;
`ifdef CIC3_SAMPLE_BUFFER_ROUND_EN
    shifted = (centered + RND) >>> SHIFT;
`else
    shifted = centered >>> SHIFT;
`endif
    if (shifted > SAT_HI)
      s1_next = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    else if (shifted < SAT_LO)
      s1_next = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else
      s1_next = shifted[OUT_WIDTH-1:0];
  end

  assign full  = (count == (AW+1)'(DEPTH));
  assign do_rd = rd.rd_valid & rd.rd_ready & ~flush;
  assign do_wr = s1_valid & ~flush & (~full | do_rd);

  assign rd.rd_valid = (count != '0);
  assign rd.rd_data  = rd.rd_valid ? mem[rd_ptr] : '0;
  assign fill_level  = count;

  always_ff @(posedge clk) begin
    if (do_wr)
      mem[wr_ptr] <= s1_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      s1_valid <= sample_stb;
      if (sample_stb)
        s1_data <= s1_next;
      if (do_wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_rd)
        rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A sample arriving at a full FIFO with no pop is lost.
      if (s1_valid & full & ~do_rd)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cic3_sample_buffer.sv
// Scoreboard bench for cic3_sample_buffer: directed cases then random traffic.
// The monitor keeps a queue model of the FIFO and compares every cycle.
module tb_cic3_sample_buffer;

  localparam int NB = 25;
  localparam int OW = 16;
  localparam int DP = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] cic_in = '0;
  logic          sample_stb = 1'b0;
  logic          flush = 1'b0;
  logic [3:0]    fill_level;
  logic          overflow;

  int n_tests = 0;
  int n_fail  = 0;

  cic3_sample_buffer_if #(.OUT_WIDTH(OW)) rd_if ();

  cic3_sample_buffer #(
    .NUMBITS(NB), .OUT_WIDTH(OW), .DEPTH(DP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cic_in(cic_in),
    .sample_stb(sample_stb),
    .flush(flush),
    .rd(rd_if),
    .fill_level(fill_level),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act,
                       input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference: floor (or round-half-up) of (x - 2^23) / 256, clamped.
  function automatic logic [OW-1:0] ref_sample(input logic [NB-1:0] x);
    longint c;
    longint q;
    c = longint'(x) - (longint'(1) << (NB - 2));
`ifdef CIC3_SAMPLE_BUFFER_ROUND_EN
    c = c + 128;
`endif
    if (c >= 0) q = c / 256;
    else        q = -((-c + 255) / 256);
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return q[OW-1:0];
  endfunction

  logic [OW-1:0] mq[$];
  logic          m_pend = 1'b0;
  logic [OW-1:0] m_pend_val = '0;
  logic          m_ovf = 1'b0;

  // Monitor: compare at negedge, then advance the model by the coming edge.
  initial begin
    logic pop;
    forever begin
      @(negedge clk);
      if (reset) begin
        mq.delete();
        m_pend = 1'b0;
        m_ovf  = 1'b0;
        check("reset_valid", rd_if.rd_valid, 0);
        check("reset_fill", fill_level, 0);
        check("reset_ovf", overflow, 0);
        check("reset_data", rd_if.rd_data, 0);
      end else begin
        check("rd_valid", rd_if.rd_valid, mq.size() != 0);
        check("fill_level", fill_level, mq.size());
        check("overflow", overflow, m_ovf);
        if (mq.size() != 0)
          check("rd_data", rd_if.rd_data, mq[0]);
        if (flush) begin
          mq.delete();
          m_pend = 1'b0;
          m_ovf  = 1'b0;
        end else begin
          pop = (mq.size() != 0) && rd_if.rd_ready;
          if (pop) void'(mq.pop_front());
          if (m_pend) begin
            if (mq.size() >= DP) m_ovf = 1'b1;
            else mq.push_back(m_pend_val);
          end
          m_pend     = sample_stb;
          m_pend_val = ref_sample(cic_in);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [NB-1:0] v);
    cic_in     = v;
    sample_stb = 1'b1;
    step();
    sample_stb = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    rd_if.rd_ready = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();

    rd_if.rd_ready = 1'b1;
    strobe(25'h0800000);
    strobe(25'h0000000);
    strobe(25'h1000000);
    strobe(25'h0800080);
    repeat (4) step();

    rd_if.rd_ready = 1'b0;
    for (int i = 1; i <= 9; i++)
      strobe(25'h0800000 + 25'(i * 256));
    repeat (2) step();
    check("ovf_fill", fill_level, 8);
    check("ovf_flag", overflow, 1);
    rd_if.rd_ready = 1'b1;
    repeat (10) step();
    do_flush();

    rd_if.rd_ready = 1'b0;
    for (int i = 1; i <= 8; i++)
      strobe(25'h0800000 + 25'(i * 512));
    step();
    strobe(25'h0C00000);
    rd_if.rd_ready = 1'b1;
    step();
    rd_if.rd_ready = 1'b0;
    check("full_rw_fill", fill_level, 8);
    check("full_rw_ovf", overflow, 0);
    rd_if.rd_ready = 1'b1;
    repeat (10) step();

    rd_if.rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) strobe(25'h0900000 + 25'(i));
    repeat (2) step();
    cic_in     = 25'h0A00000;
    flush      = 1'b1;
    sample_stb = 1'b1;
    step();
    flush      = 1'b0;
    sample_stb = 1'b0;
    check("flush_fill", fill_level, 0);
    check("flush_ovf", overflow, 0);
    rd_if.rd_ready = 1'b1;
    repeat (4) step();

    rd_if.rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) strobe(25'h0700000 + 25'(i * 256));
    step();
    strobe(25'h0123456);
    reset = 1'b1;
    #1;
    check("rst_mid_valid", rd_if.rd_valid, 0);
    check("rst_mid_fill", fill_level, 0);
    step();
    reset = 1'b0;
    step();
    rd_if.rd_ready = 1'b1;
    strobe(25'h0812345);
    repeat (4) step();

    for (int blk = 0; blk < 15; blk++) begin
      int rdy_pct;
      rdy_pct = $urandom_range(0, 100);
      for (int c = 0; c < 200; c++) begin
        int r;
        r = $urandom_range(0, 9);
        case (r)
          0:       cic_in = '0;
          1:       cic_in = 25'h1000000;
          2:       cic_in = 25'h0800000;
          default: cic_in = 25'($urandom_range(0, 32'h1000000));
        endcase
        sample_stb     = $urandom_range(0, 1) == 1;
        rd_if.rd_ready = $urandom_range(1, 100) <= rdy_pct;
        flush          = $urandom_range(0, 99) == 0;
        step();
      end
    end
    sample_stb     = 1'b0;
    flush          = 1'b0;
    rd_if.rd_ready = 1'b1;
    repeat (12) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
